receptor_dual_rail: RTL and testbench

//  Clocked receiver for the dual-rail (two wires per bit) result bus of the asynchronous adder datapath.

---
 rtl/receptor_dual_rail.sv | 150 +++++++++++++++
 tb/tb_receptor_dual_rail.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_dual_rail.sv
// Clocked receiver for a dual-rail sum/carry bus. It synchronises every rail, detects
// completion and illegal codes, captures the word as binary and returns a 4-phase ack.
module receptor_dual_rail #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] s_dr,
    input  logic [1:0]         cout_dr,
    output logic               ack,
    output logic [WIDTH-1:0]   dout,
    output logic               cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               code_err,
    output logic               timeout,
    input  logic               clr_err
);

    localparam int RW    = 2*WIDTH + 2;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE,
        ACK_HI
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    sync_q [SYNC_STAGES];
    logic [RW-1:0]    sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             code_err_q, code_err_d;
    logic             timeout_q, timeout_d;

    logic [RW-1:0]    s_q;
    logic [WIDTH-1:0] rail1;
    logic             complete;
    logic             any_illegal;
    logic             all_null;
    logic             capture;
    logic             err_set;
    logic             to_set;

    // The carry pair sits above the sum pairs so pair index WIDTH is the carry.
    always_comb begin
        sync_d[0] = {cout_dr, s_dr};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_q = sync_q[SYNC_STAGES-1];

    always_comb begin
        complete    = 1'b1;
        any_illegal = 1'b0;
        rail1       = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (s_q[2*i +: 2] == 2'b00) complete = 1'b0;
            if (s_q[2*i +: 2] == 2'b11) any_illegal = 1'b1;
        end
        for (int i = 0; i < WIDTH; i++) begin
            rail1[i] = s_q[2*i+1];
        end
    end

    assign all_null = (s_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        err_set = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (complete) begin
                    if (any_illegal) begin
                        err_set = 1'b1;
                        state_d = ACK_HI;
                    end else if (!out_valid_q || out_ready) begin
                        capture = 1'b1;
                        state_d = ACK_HI;
                    end
                end
            end
            ACK_HI: begin
                if (all_null) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    to_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture overrides the consumer's accept; a flag set overrides clr_err.
    always_comb begin
        dout_d      = capture ? rail1 : dout_q;
        cout_d      = capture ? s_q[RW-1] : cout_q;
        out_valid_d = capture ? 1'b1 : ((out_valid_q && out_ready) ? 1'b0 : out_valid_q);
        code_err_d  = err_set ? 1'b1 : (clr_err ? 1'b0 : code_err_q);
        timeout_d   = to_set ? 1'b1 : (clr_err ? 1'b0 : timeout_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dout_q      <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            code_err_q  <= code_err_d;
            timeout_q   <= timeout_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign ack       = (state_q == ACK_HI);
    assign dout      = dout_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
    assign code_err  = code_err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_receptor_dual_rail.sv
// Directed bench for receptor_dual_rail: expected words are queued when driven and
// compared when the receiver raises ack; handshake timing is checked edge by edge.
module tb_receptor_dual_rail;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_dr;
    logic [1:0] cout_dr;
    logic       ack;
    logic [3:0] dout;
    logic       cout;
    logic       out_valid;
    logic       out_ready;
    logic       code_err;
    logic       timeout;
    logic       clr_err;

    typedef struct {
        logic [3:0] d;
        logic       c;
    } word_t;

    word_t scoreboard[$];
    int    checks   = 0;
    int    failures = 0;

    receptor_dual_rail #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_dr     (s_dr),
        .cout_dr  (cout_dr),
        .ack      (ack),
        .dout     (dout),
        .cout     (cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .code_err (code_err),
        .timeout  (timeout),
        .clr_err  (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] encWord(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    function automatic logic [1:0] encBit(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
    task automatic applyStimulus(input logic [7:0] s, input logic [1:0] c);
        @(posedge clk);
        #1;
        s_dr    = s;
        cout_dr = c;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input logic [3:0] d, input logic c);
        word_t w;
        w.d = d;
        w.c = c;
        scoreboard.push_back(w);
    endtask

    task automatic checkWord(input string tag);
        word_t w;
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s: observed=empty_queue expected=word", tag);
        end else begin
            w = scoreboard.pop_front();
            checkOutput({tag, "_dout"}, 32'(dout), 32'(w.d));
            checkOutput({tag, "_cout"}, 32'(cout), 32'(w.c));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_dr      = encWord(4'hA);
        cout_dr   = 2'b01;
        out_ready = 1'b1;
        clr_err   = 1'b0;

        $display("[TB] reset with active rails");
        waitEdges(4);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_code_err", 32'(code_err), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);

        applyStimulus(8'b10_00_01_10, 2'b01);
        rst_n = 1'b1;
        waitEdges(6);
        checkOutput("partial_ack", 32'(ack), 32'd0);
        checkOutput("partial_valid", 32'(out_valid), 32'd0);
        checkOutput("partial_err", 32'(code_err), 32'd0);

        $display("[TB] single word");
        pushWord(4'b1001, 1'b0);
        applyStimulus(8'b10_01_01_10, 2'b01);
        waitEdges(2);
        checkOutput("word_ack_early", 32'(ack), 32'd0);
        waitEdges(1);
        checkOutput("word_ack", 32'(ack), 32'd1);
        checkOutput("word_valid", 32'(out_valid), 32'd1);
        checkWord("word");
        applyStimulus(8'h00, 2'b00);
        waitEdges(2);
        checkOutput("null_ack_early", 32'(ack), 32'd1);
        waitEdges(1);
        checkOutput("null_ack", 32'(ack), 32'd0);
        checkOutput("word_valid_cleared", 32'(out_valid), 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        pushWord(4'b1111, 1'b0);
        applyStimulus(encWord(4'b1111), encBit(1'b0));
        waitEdges(3);
        checkOutput("bp1_ack", 32'(ack), 32'd1);
        checkWord("bp1");
        applyStimulus(8'h00, 2'b00);
        waitEdges(3);
        checkOutput("bp1_null_ack", 32'(ack), 32'd0);
        pushWord(4'b0011, 1'b1);
        applyStimulus(encWord(4'b0011), encBit(1'b1));
        waitEdges(6);
        checkOutput("bp2_ack_held", 32'(ack), 32'd0);
        checkOutput("bp2_dout_held", 32'(dout), 32'hF);
        checkOutput("bp2_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        waitEdges(1);
        checkOutput("bp2_ack", 32'(ack), 32'd1);
        checkOutput("bp2_valid", 32'(out_valid), 32'd1);
        checkWord("bp2");
        applyStimulus(8'h00, 2'b00);
        waitEdges(3);
        checkOutput("bp2_null_ack", 32'(ack), 32'd0);
        checkOutput("bp2_valid_cleared", 32'(out_valid), 32'd0);

        $display("[TB] illegal code");
        applyStimulus(8'b01_11_10_01, 2'b01);
        waitEdges(3);
        checkOutput("ill_ack", 32'(ack), 32'd1);
        checkOutput("ill_code_err", 32'(code_err), 32'd1);
        checkOutput("ill_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_dout_kept", 32'(dout), 32'h3);
        applyStimulus(8'h00, 2'b00);
        waitEdges(3);
        checkOutput("ill_null_ack", 32'(ack), 32'd0);
        checkOutput("ill_err_sticky", 32'(code_err), 32'd1);
        clr_err = 1'b1;
        waitEdges(1);
        clr_err = 1'b0;
        checkOutput("ill_err_cleared", 32'(code_err), 32'd0);

        $display("[TB] timeout");
        pushWord(4'b0101, 1'b1);
        applyStimulus(encWord(4'b0101), encBit(1'b1));
        waitEdges(3);
        checkOutput("to_ack", 32'(ack), 32'd1);
        checkWord("to");
        waitEdges(63);
        checkOutput("to_not_yet", 32'(timeout), 32'd0);
        waitEdges(1);
        checkOutput("to_set", 32'(timeout), 32'd1);
        checkOutput("to_ack_held", 32'(ack), 32'd1);
        waitEdges(10);
        checkOutput("to_ack_still", 32'(ack), 32'd1);
        applyStimulus(8'h00, 2'b00);
        waitEdges(3);
        checkOutput("to_null_ack", 32'(ack), 32'd0);
        checkOutput("to_sticky", 32'(timeout), 32'd1);
        clr_err = 1'b1;
        waitEdges(1);
        clr_err = 1'b0;
        checkOutput("to_cleared", 32'(timeout), 32'd0);

        $display("[TB] reset during handshake");
        pushWord(4'b0110, 1'b0);
        applyStimulus(encWord(4'b0110), encBit(1'b0));
        waitEdges(3);
        checkOutput("mid_ack", 32'(ack), 32'd1);
        checkWord("mid");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ack", 32'(ack), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_dout", 32'(dout), 32'd0);
        pushWord(4'b0110, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitEdges(2);
        checkOutput("recap_ack_early", 32'(ack), 32'd0);
        waitEdges(1);
        checkOutput("recap_ack", 32'(ack), 32'd1);
        checkOutput("recap_valid", 32'(out_valid), 32'd1);
        checkWord("recap");
        checkOutput("queue_drained", 32'(scoreboard.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
